// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types for the FS UTM: line-state encoding, receive FSM states
// and EOP limits.
package usb_utmi_pkg;

   typedef enum logic [1:0] {
      LS_SE0 = 2'b00,
      LS_J   = 2'b01,
      LS_K   = 2'b10,
      LS_SE1 = 2'b11
   } utmi_line_state_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_EOP,
      ST_ABORT
   } usb_utm_rx_state_t;

   localparam int USB_EOP_SE0_MAX = 3;

endpackage

// File: rtl/usb_utm_rx.sv
// FS UTM receive byte assembler: SYNC hunt, LSB-first byte assembly, EOP and error detection.
// Optional missing-stuff-bit detection is enabled by defining USB_UTM_RX_STUFF_ERR_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | bus idle, waiting for the first K of SYNC
// ST_SYNC  | counting decoded 0s, waiting for the terminating 1
// ST_DATA  | assembling bytes, rx_active high
// ST_EOP   | SE0 seen, waiting for J (or timeout / K)
// ST_ABORT | error seen, rx_active held until two idle J strobes
module usb_utm_rx
   import usb_utmi_pkg::*;
#(
   parameter int SYNC_MIN_ZEROS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_strobe,
   input  logic       bit_data,
   input  logic       bit_stuffed,
   input  logic [1:0] line_state,
   output logic       rx_active,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_error
);

   usb_utm_rx_state_t state_q;
   utmi_line_state_t  ls;
   logic [2:0]        zero_cnt_q;
   logic [2:0]        bit_cnt_q;
   logic [1:0]        se0_cnt_q;
   logic              j_cnt_q;
   logic [6:0]        shreg_q;
   logic              rx_active_q;
   logic              rx_valid_q;
   logic [7:0]        rx_data_q;
   logic              rx_error_q;
`ifdef USB_UTM_RX_STUFF_ERR_EN
   logic [2:0]        ones_cnt_q;
`endif

   assign ls = utmi_line_state_t'(line_state);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         zero_cnt_q  <= 3'd0;
         bit_cnt_q   <= 3'd0;
         se0_cnt_q   <= 2'd0;
         j_cnt_q     <= 1'b0;
         shreg_q     <= 7'd0;
         rx_active_q <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_error_q  <= 1'b0;
`ifdef USB_UTM_RX_STUFF_ERR_EN
         ones_cnt_q  <= 3'd0;
`endif
      end else begin
         rx_valid_q <= 1'b0;
         rx_error_q <= 1'b0;
         if (bit_strobe) begin
            case (state_q)
               ST_IDLE: begin
                  if (ls == LS_K) begin
                     state_q    <= ST_SYNC;
                     zero_cnt_q <= 3'd0;
                  end
               end
               ST_SYNC: begin
                  if (ls == LS_SE0) begin
                     state_q <= ST_IDLE;
                  end else if (!bit_data) begin
                     if (zero_cnt_q != 3'd7) zero_cnt_q <= zero_cnt_q + 3'd1;
                  end else if (int'(zero_cnt_q) >= SYNC_MIN_ZEROS) begin
                     state_q     <= ST_DATA;
                     rx_active_q <= 1'b1;
                     bit_cnt_q   <= 3'd0;
`ifdef USB_UTM_RX_STUFF_ERR_EN
                     ones_cnt_q  <= 3'd0;
`endif
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_DATA: begin
                  if (ls == LS_SE0) begin
                     // a partially filled byte at EOP is discarded and flagged
                     state_q   <= ST_EOP;
                     se0_cnt_q <= 2'd1;
                     if (bit_cnt_q != 3'd0) rx_error_q <= 1'b1;
                  end else if (bit_stuffed) begin
`ifdef USB_UTM_RX_STUFF_ERR_EN
                     ones_cnt_q <= 3'd0;
`endif
                  end
`ifdef USB_UTM_RX_STUFF_ERR_EN
                  else if (bit_data && ones_cnt_q == 3'd6) begin
                     state_q    <= ST_ABORT;
                     j_cnt_q    <= 1'b0;
                     rx_error_q <= 1'b1;
                  end
`endif
                  else begin
                     shreg_q   <= {bit_data, shreg_q[6:1]};
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        rx_data_q  <= {bit_data, shreg_q};
                        rx_valid_q <= 1'b1;
                     end
`ifdef USB_UTM_RX_STUFF_ERR_EN
                     ones_cnt_q <= bit_data ? ones_cnt_q + 3'd1 : 3'd0;
`endif
                  end
               end
               ST_EOP: begin
                  if (ls == LS_SE0) begin
                     if (se0_cnt_q >= 2'(USB_EOP_SE0_MAX)) begin
                        state_q    <= ST_ABORT;
                        j_cnt_q    <= 1'b0;
                        rx_error_q <= 1'b1;
                     end else begin
                        se0_cnt_q <= se0_cnt_q + 2'd1;
                     end
                  end else if (ls == LS_J) begin
                     state_q     <= ST_IDLE;
                     rx_active_q <= 1'b0;
                  end else begin
                     state_q    <= ST_ABORT;
                     j_cnt_q    <= 1'b0;
                     rx_error_q <= 1'b1;
                  end
               end
               ST_ABORT: begin
                  if (ls == LS_J) begin
                     if (j_cnt_q) begin
                        state_q     <= ST_IDLE;
                        rx_active_q <= 1'b0;
                        j_cnt_q     <= 1'b0;
                     end else begin
                        j_cnt_q <= 1'b1;
                     end
                  end else begin
                     j_cnt_q <= 1'b0;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign rx_active = rx_active_q;
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign rx_error  = rx_error_q;

endmodule

// File: tb/tb_usb_utm_rx.sv
// Self-checking bench for usb_utm_rx: packet table, hand-written timing/reset
// sequences and randomized packets against a packet-level reference model.
module tb_usb_utm_rx;
   import usb_utmi_pkg::*;

   localparam int SYNC_MIN = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bit_strobe = 1'b0;
   logic       bit_data = 1'b0;
   logic       bit_stuffed = 1'b0;
   logic [1:0] line_state = LS_J;
   logic       rx_active;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_error;

   usb_utm_rx #(.SYNC_MIN_ZEROS(SYNC_MIN)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_strobe  (bit_strobe),
      .bit_data    (bit_data),
      .bit_stuffed (bit_stuffed),
      .line_state  (line_state),
      .rx_active   (rx_active),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_error    (rx_error)
   );

   always #10 clk = ~clk;

   typedef struct {
      string       name;
      int          nz;
      logic [31:0] data;
      int          nbits;
      int          n_se0;
      logic [1:0]  tail;
      int          exp_n;
      logic [7:0]  exp_b0;
      logic [7:0]  exp_b1;
      int          exp_err;
      logic        exp_tail_act;
      int          exp_gap;
   } vec_t;

   vec_t vecs[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int err_seen = 0;
   int mon_bad = 0;
   logic prev_valid = 1'b0;
   logic prev_error = 1'b0;
   logic [7:0] got_q[$];
   int vtime_q[$];
   logic [7:0] exp_q[$];

   logic       post_active, post_valid, post_error;
   logic [7:0] post_data;
   logic       tail_active, end_active;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            got_q.push_back(rx_data);
            vtime_q.push_back(cyc);
         end
         if (rx_error) err_seen++;
         if ((rx_valid && rx_error) || (rx_valid && prev_valid) || (rx_error && prev_error))
            mon_bad++;
      end
      prev_valid = rx_valid;
      prev_error = rx_error;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_bit(input logic [1:0] ls, input logic b, input logic st);
      @(negedge clk);
      bit_strobe  = 1'b1;
      bit_data    = b;
      bit_stuffed = st;
      line_state  = ls;
      @(negedge clk);
      bit_strobe  = 1'b0;
      bit_stuffed = 1'b0;
      post_active = rx_active;
      post_valid  = rx_valid;
      post_error  = rx_error;
      post_data   = rx_data;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic send_sync(input int nz);
      send_bit(LS_K, 1'b0, 1'b0);
      for (int i = 0; i < nz; i++) send_bit(LS_J, 1'b0, 1'b0);
      send_bit(LS_K, 1'b1, 1'b0);
   endtask

   // inserts a stuffed 0 after every six consecutive data 1s
   task automatic send_data(input logic [31:0] d, input int nbits);
      int ones;
      ones = 0;
      for (int i = 0; i < nbits; i++) begin
         send_bit(LS_J, d[i], 1'b0);
         ones = d[i] ? ones + 1 : 0;
         if (ones == 6) begin
            send_bit(LS_J, 1'b0, 1'b1);
            ones = 0;
         end
      end
   endtask

   task automatic send_eop(input int n_se0, input logic [1:0] tail);
      for (int i = 0; i < n_se0; i++) send_bit(LS_SE0, 1'b0, 1'b0);
      send_bit(tail, 1'b0, 1'b0);
      tail_active = post_active;
      send_bit(LS_J, 1'b0, 1'b0);
      send_bit(LS_J, 1'b0, 1'b0);
      end_active = post_active;
   endtask

   task automatic clear_mon();
      got_q.delete();
      vtime_q.delete();
      err_seen = 0;
   endtask

   task automatic check_pkt(input string nm, input int exp_err, input logic exp_tail, input int exp_gap);
      chk({nm, ".nvalid"}, got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
         chk($sformatf("%s.byte%0d", nm, k), got_q[k], exp_q[k]);
      chk({nm, ".nerr"}, err_seen, exp_err);
      chk({nm, ".tail_active"}, tail_active, exp_tail);
      chk({nm, ".end_active"}, end_active, 1'b0);
      if (exp_gap > 0 && vtime_q.size() >= 2)
         chk({nm, ".gap"}, vtime_q[1] - vtime_q[0], exp_gap);
   endtask

   task automatic add_vec(input string nm, input int nz, input logic [31:0] d, input int nb,
                          input int ns, input logic [1:0] tl, input int en, input logic [7:0] b0,
                          input logic [7:0] b1, input int ee, input logic et, input int eg);
      vec_t v;
      v.name = nm; v.nz = nz; v.data = d; v.nbits = nb; v.n_se0 = ns; v.tail = tl;
      v.exp_n = en; v.exp_b0 = b0; v.exp_b1 = b1; v.exp_err = ee; v.exp_tail_act = et;
      v.exp_gap = eg;
      vecs.push_back(v);
   endtask

   task automatic run_vec(input vec_t v);
      clear_mon();
      send_sync(v.nz);
      send_data(v.data, v.nbits);
      send_eop(v.n_se0, v.tail);
      exp_q.delete();
      if (v.exp_n > 0) exp_q.push_back(v.exp_b0);
      if (v.exp_n > 1) exp_q.push_back(v.exp_b1);
      check_pkt(v.name, v.exp_err, v.exp_tail_act, v.exp_gap);
   endtask

   int          r_nz, r_nby, r_ext, r_nbits, r_nse0, r_err;
   logic [31:0] r_data;
   logic [1:0]  r_tail;
   logic        r_sync, r_abort;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //      name        nz data        nb se0 tail   n  b0     b1     err tail gap
      add_vec("clean",     6, 32'h3CA5, 16, 2, LS_J, 2, 8'hA5, 8'h3C, 0, 1'b0, 32);
      add_vec("stuff_ff",  6, 32'h00FF,  8, 2, LS_J, 1, 8'hFF, 8'h00, 0, 1'b0, 0);
      add_vec("stuff_gap", 6, 32'h0FFC, 16, 2, LS_J, 2, 8'hFC, 8'h0F, 0, 1'b0, 36);
      add_vec("partial",   6, 32'h1612, 13, 2, LS_J, 1, 8'h12, 8'h00, 1, 1'b0, 0);
      add_vec("false_syn", 2, 32'h0055,  8, 2, LS_J, 0, 8'h00, 8'h00, 0, 1'b0, 0);
      add_vec("min_sync",  4, 32'h0081,  8, 2, LS_J, 1, 8'h81, 8'h00, 0, 1'b0, 0);
      add_vec("below_min", 3, 32'h0081,  8, 2, LS_J, 0, 8'h00, 8'h00, 0, 1'b0, 0);
      add_vec("eop_k",     6, 32'h00C3,  8, 1, LS_K, 1, 8'hC3, 8'h00, 1, 1'b1, 0);
      add_vec("eop_tmo",   6, 32'h005A,  8, 5, LS_J, 1, 8'h5A, 8'h00, 1, 1'b1, 0);
      add_vec("eop_3se0",  6, 32'h0024,  8, 3, LS_J, 1, 8'h24, 8'h00, 0, 1'b0, 0);
      add_vec("part_k",    6, 32'h0005,  3, 1, LS_K, 0, 8'h00, 8'h00, 2, 1'b1, 0);
      add_vec("empty",     6, 32'h0000,  0, 2, LS_J, 0, 8'h00, 8'h00, 0, 1'b0, 0);

      repeat (3) @(negedge clk);
      chk("reset.active", rx_active, 1'b0);
      chk("reset.valid",  rx_valid,  1'b0);
      chk("reset.data",   rx_data,   8'h00);
      chk("reset.error",  rx_error,  1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // rx_active / rx_valid cycle-level timing
      clear_mon();
      send_bit(LS_K, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) send_bit(LS_J, 1'b0, 1'b0);
      chk("tim.pre_active", post_active, 1'b0);
      send_bit(LS_K, 1'b1, 1'b0);
      chk("tim.rise_active", post_active, 1'b1);
      send_data(32'h3C, 7);
      chk("tim.no_valid_7", post_valid, 1'b0);
      send_bit(LS_J, 1'b0, 1'b0);
      chk("tim.valid_8", post_valid, 1'b1);
      chk("tim.data_8", post_data, 8'h3C);
      send_bit(LS_SE0, 1'b0, 1'b0);
      send_bit(LS_SE0, 1'b0, 1'b0);
      chk("tim.eop_active", post_active, 1'b1);
      send_bit(LS_J, 1'b0, 1'b0);
      chk("tim.fall_active", post_active, 1'b0);
      chk("tim.nerr", err_seen, 0);

      // long run of 1s in DATA
      clear_mon();
      send_sync(6);
`ifdef USB_UTM_RX_STUFF_ERR_EN
      for (int i = 0; i < 6; i++) send_bit(LS_J, 1'b1, 1'b0);
      chk("ones.no_err_6", post_error, 1'b0);
      send_bit(LS_J, 1'b1, 1'b0);
      chk("ones.err_7", post_error, 1'b1);
      chk("ones.valid_7", post_valid, 1'b0);
      send_bit(LS_J, 1'b0, 1'b0);
      chk("ones.active_j1", post_active, 1'b1);
      send_bit(LS_J, 1'b0, 1'b0);
      chk("ones.active_j2", post_active, 1'b0);
      chk("ones.nvalid", got_q.size(), 0);
      chk("ones.nerr", err_seen, 1);
`else
      for (int i = 0; i < 8; i++) send_bit(LS_J, 1'b1, 1'b0);
      chk("ones.valid_8", post_valid, 1'b1);
      chk("ones.data_8", post_data, 8'hFF);
      send_bit(LS_SE0, 1'b0, 1'b0);
      send_bit(LS_SE0, 1'b0, 1'b0);
      send_bit(LS_J, 1'b0, 1'b0);
      chk("ones.fall_active", post_active, 1'b0);
      chk("ones.nerr", err_seen, 0);
`endif

      // asynchronous reset in the middle of a byte
      clear_mon();
      send_sync(6);
      send_data(32'hA5, 8);
      send_data(32'h0B, 4);
      chk("rst.pre_active", rx_active, 1'b1);
      chk("rst.pre_data", rx_data, 8'hA5);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst.active", rx_active, 1'b0);
      chk("rst.valid",  rx_valid,  1'b0);
      chk("rst.data",   rx_data,   8'h00);
      chk("rst.error",  rx_error,  1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.nerr", err_seen, 0);
      run_vec(vecs[0]);

      // randomized packets against the packet-level model
      for (int r = 0; r < 40; r++) begin
         r_nz    = int'($urandom_range(0, 9));
         r_nby   = int'($urandom_range(0, 3));
         r_ext   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
         r_nbits = r_nby * 8 + r_ext;
         r_data  = $urandom;
         r_nse0  = int'($urandom_range(1, 5));
         r_sync  = (r_nz >= SYNC_MIN);
         r_tail  = (r_sync && $urandom_range(0, 3) == 0) ? LS_K : LS_J;

         exp_q.delete();
         r_err   = 0;
         r_abort = 1'b0;
         if (r_sync) begin
            for (int k = 0; k < r_nby; k++) exp_q.push_back(r_data[8*k +: 8]);
            if (r_ext != 0) r_err++;
            r_abort = (r_nse0 > USB_EOP_SE0_MAX) || (r_tail == LS_K);
            if (r_abort) r_err++;
         end

         clear_mon();
         send_sync(r_nz);
         send_data(r_data, r_nbits);
         send_eop(r_nse0, r_tail);
         check_pkt($sformatf("rnd%0d", r), r_err, r_abort, 0);
      end

      chk("mon.pulse_rules", mon_bad, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
